parking_gate_controller: RTL and testbench

- Sequencing controller for the smart-parking datapath. It owns an 8-slot occupancy map, arbitrates between an entry gate and an exit gate, and allocates slots and issues scrambled tokens on entry.
- On exit it validates the token, frees the slot and reports the parking duration.
- It sits between the gate sensors/keypads and the display/billing logic, and replaces externally supplied capacity and timestamps with registered state.

---
 rtl/parking_gate_controller.sv | 194 +++++++++++++++++++
 tb/tb_parking_gate_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Parking gate controller: owns an 8-slot occupancy map, arbitrates entry/exit gate
// requests round-robin, issues scrambled tokens and reports parking durations.
module parking_gate_controller #(
    parameter int unsigned GATE_CYCLES = 4,
    parameter int unsigned TICK_DIV    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_token,
    input  logic [2:0] pattern,
    output logic       entry_ack,
    output logic       exit_ack,
    output logic       accept,
    output logic [2:0] token_out,
    output logic [7:0] time_total,
    output logic       gate_open,
    output logic [7:0] occupancy,
    output logic [3:0] parked,
    output logic [3:0] empty
);

    typedef enum logic [1:0] {StIdle, StServe, StGate, StWait} state_e;

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e          state_q, state_d;
    logic            serve_exit_q, serve_exit_d;
    logic            last_exit_q, last_exit_d;
    logic [7:0]      gate_cnt_q, gate_cnt_d;
    logic [DivW-1:0] div_q;
    logic [7:0]      time_q;
    logic [7:0]      ts_q [8];
    logic            ts_we;
    logic [2:0]      ts_idx;
    logic [7:0]      occ_q, occ_d;
    logic [3:0]      parked_q, parked_d;
    logic [3:0]      empty_q, empty_d;
    logic [2:0]      token_q, token_d;
    logic [7:0]      total_q, total_d;
    logic            entry_ack_q, entry_ack_d;
    logic            exit_ack_q, exit_ack_d;
    logic            accept_q, accept_d;
    logic            gate_q, gate_d;
    logic [2:0]      free_idx;
    logic            full;
    logic [2:0]      exit_slot;

    // Free-running time base: one tick every TICK_DIV cycles, wrapping at 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            time_q <= 8'd0;
        end else if (div_q == DivW'(TICK_DIV - 1)) begin
            div_q  <= '0;
            time_q <= time_q + 8'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = 3'(i);
        end
    end

    assign full      = &occ_q;
    assign exit_slot = exit_token ^ pattern;

    always_comb begin
        state_d      = state_q;
        serve_exit_d = serve_exit_q;
        last_exit_d  = last_exit_q;
        gate_cnt_d   = gate_cnt_q;
        occ_d        = occ_q;
        token_d      = token_q;
        total_d      = total_q;
        entry_ack_d  = 1'b0;
        exit_ack_d   = 1'b0;
        accept_d     = 1'b0;
        ts_we        = 1'b0;
        ts_idx       = free_idx;

        unique case (state_q)
            StIdle: begin
                if (entry_req && exit_req) begin
                    serve_exit_d = ~last_exit_q;
                    state_d      = StServe;
                end else if (entry_req || exit_req) begin
                    serve_exit_d = exit_req;
                    state_d      = StServe;
                end
            end
            StServe: begin
                last_exit_d = serve_exit_q;
                state_d     = StWait;
                if (!serve_exit_q) begin
                    entry_ack_d = 1'b1;
                    if (!full) begin
                        occ_d[free_idx] = 1'b1;
                        ts_we           = 1'b1;
                        token_d         = free_idx ^ pattern;
                        accept_d        = 1'b1;
                        state_d         = StGate;
                    end
                end else begin
                    exit_ack_d = 1'b1;
                    if (occ_q[exit_slot]) begin
                        occ_d[exit_slot] = 1'b0;
                        total_d          = time_q - ts_q[exit_slot];
                        accept_d         = 1'b1;
                        state_d          = StGate;
                    end
                end
                gate_cnt_d = 8'(GATE_CYCLES - 1);
            end
            StGate: begin
                if (gate_cnt_q == 8'd0) begin
                    state_d = StWait;
                end else begin
                    gate_cnt_d = gate_cnt_q - 8'd1;
                end
            end
            StWait: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so the actuator follows the GATE state without a decode glitch.
        gate_d = (state_d == StGate);
    end

    always_comb begin
        parked_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            parked_d = parked_d + {3'd0, occ_d[i]};
        end
        empty_d = 4'd8 - parked_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            serve_exit_q <= 1'b0;
            last_exit_q  <= 1'b1;
            gate_cnt_q   <= 8'd0;
            occ_q        <= 8'd0;
            parked_q     <= 4'd0;
            empty_q      <= 4'd8;
            token_q      <= 3'd0;
            total_q      <= 8'd0;
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            accept_q     <= 1'b0;
            gate_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            serve_exit_q <= serve_exit_d;
            last_exit_q  <= last_exit_d;
            gate_cnt_q   <= gate_cnt_d;
            occ_q        <= occ_d;
            parked_q     <= parked_d;
            empty_q      <= empty_d;
            token_q      <= token_d;
            total_q      <= total_d;
            entry_ack_q  <= entry_ack_d;
            exit_ack_q   <= exit_ack_d;
            accept_q     <= accept_d;
            gate_q       <= gate_d;
        end
    end

    // Arrival timestamps are only meaningful while the slot bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (ts_we) ts_q[ts_idx] <= time_q;
    end

    assign entry_ack  = entry_ack_q;
    assign exit_ack   = exit_ack_q;
    assign accept     = accept_q;
    assign token_out  = token_q;
    assign time_total = total_q;
    assign gate_open  = gate_q;
    assign occupancy  = occ_q;
    assign parked     = parked_q;
    assign empty      = empty_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: a slot-level reference model predicts
// every ack, and a monitor checks each cycle's outputs against the predicted state.
module tb_parking_gate_controller;

    localparam int GC = 4;
    localparam int TD = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_token = 3'd0;
    logic [2:0] pattern = 3'd0;
    logic       entry_ack, exit_ack, accept, gate_open;
    logic [2:0] token_out;
    logic [7:0] time_total, occupancy;
    logic [3:0] parked, empty;

    parking_gate_controller #(
        .GATE_CYCLES(GC),
        .TICK_DIV   (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .exit_token(exit_token),
        .pattern   (pattern),
        .entry_ack (entry_ack),
        .exit_ack  (exit_ack),
        .accept    (accept),
        .token_out (token_out),
        .time_total(time_total),
        .gate_open (gate_open),
        .occupancy (occupancy),
        .parked    (parked),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_exit;
        bit       acc;
        bit [2:0] token;
        bit [7:0] total;
        bit [7:0] occ;
        int       ack_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edges;

    // Reference model: which slots hold a car, when each arrived, last side served.
    bit       m_occ [8];
    int       m_ts [8];
    bit       m_last_exit;
    bit [2:0] m_token;
    bit [7:0] m_total;

    // Monitor's view of the currently expected held outputs.
    bit [7:0] mon_occ;
    bit [2:0] mon_token;
    bit [7:0] mon_total;
    int       gate_start;
    exp_t     mon_e;

    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int popc(input bit [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic exp_t model_serve(input bit is_exit, input bit [2:0] tok,
                                         input int serve_cyc);
        exp_t e;
        int   tc;
        int   s;
        tc        = (serve_cyc / TD) % 256;
        s         = -1;
        e.is_exit = is_exit;
        e.acc     = 1'b0;
        e.ack_cyc = serve_cyc + 1;
        if (!is_exit) begin
            for (int i = 7; i >= 0; i--) if (!m_occ[i]) s = i;
            if (s >= 0) begin
                m_occ[s] = 1'b1;
                m_ts[s]  = tc;
                m_token  = 3'(s) ^ pattern;
                e.acc    = 1'b1;
            end
        end else begin
            s = int'(tok ^ pattern);
            if (m_occ[s]) begin
                m_occ[s] = 1'b0;
                m_total  = 8'((tc - m_ts[s] + 256) % 256);
                e.acc    = 1'b1;
            end
        end
        m_last_exit = is_exit;
        e.token     = m_token;
        e.total     = m_total;
        for (int i = 0; i < 8; i++) e.occ[i] = m_occ[i];
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (entry_ack || exit_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'({entry_ack, exit_ack}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_side", 32'({entry_ack, exit_ack}),
                        mon_e.is_exit ? 32'd1 : 32'd2);
                    chk("accept", 32'(accept), 32'(mon_e.acc));
                    chk("ack_cycle", 32'(edges), 32'(mon_e.ack_cyc));
                    mon_occ   = mon_e.occ;
                    mon_token = mon_e.token;
                    mon_total = mon_e.total;
                    if (mon_e.acc) gate_start = edges;
                end
            end else begin
                chk("accept_idle", 32'(accept), 32'd0);
            end
            chk("occupancy", 32'(occupancy), 32'(mon_occ));
            chk("parked", 32'(parked), 32'(popc(mon_occ)));
            chk("empty", 32'(empty), 32'(8 - popc(mon_occ)));
            chk("token_out", 32'(token_out), 32'(mon_token));
            chk("time_total", 32'(time_total), 32'(mon_total));
            chk("gate_open", 32'(gate_open),
                32'((edges >= gate_start) && (edges < gate_start + GC)));
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_occ[i] = 1'b0;
        m_last_exit = 1'b1;
        m_token     = 3'd0;
        m_total     = 8'd0;
        mon_occ     = 8'd0;
        mon_token   = 3'd0;
        mon_total   = 8'd0;
        gate_start  = -1000;
        #1;
        chk("rst_gate_open", 32'(gate_open), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_parked", 32'(parked), 32'd0);
        chk("rst_empty", 32'(empty), 32'd8);
        chk("rst_token", 32'(token_out), 32'd0);
        chk("rst_total", 32'(time_total), 32'd0);
        chk("rst_acks", 32'({entry_ack, exit_ack, accept}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a falling edge while the DUT is idle; returns at the ack edge or settled.
    task automatic txn(input bit en, input bit ex, input bit [2:0] tok, input bit settle);
        exp_t e1, e2;
        int   serve1;
        bit   first_exit;
        exit_token = tok;
        serve1     = edges + 1;
        first_exit = (en && ex) ? !m_last_exit : ex;
        e1 = model_serve(first_exit, tok, serve1);
        exp_q.push_back(e1);
        if (en && ex) begin
            e2 = model_serve(!first_exit, tok, serve1 + (e1.acc ? GC + 3 : 3));
            exp_q.push_back(e2);
        end
        entry_req = en;
        exit_req  = ex;
        for (int t = 0; t < 200 && (entry_req || exit_req); t++) begin
            @(negedge clk);
            if (entry_ack) entry_req = 1'b0;
            if (exit_ack)  exit_req  = 1'b0;
        end
        chk("handshake_done", 32'({entry_req, exit_req}), 32'd0);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        if (settle) repeat (GC + 1) @(negedge clk);
    endtask

    task automatic wait_serve_at(input int tc);
        for (int t = 0; t < 300 * TD && ((edges + 1) / TD) % 256 != tc; t++) @(negedge clk);
    endtask

    function automatic bit [2:0] pick_token();
        int occ_slots[$];
        for (int i = 0; i < 8; i++) if (m_occ[i]) occ_slots.push_back(i);
        if (occ_slots.size() > 0 && $urandom_range(0, 3) != 0)
            return 3'(occ_slots[$urandom_range(0, occ_slots.size() - 1)]) ^ pattern;
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        #2;
        do_reset();

        // Timed stay of 25 ticks, slot reuse, then an exit naming an empty slot.
        pattern = 3'b101;
        wait_serve_at(10);
        txn(1'b1, 1'b0, 3'd0, 1'b1);
        wait_serve_at(35);
        txn(1'b0, 1'b1, 3'd5, 1'b1);
        txn(1'b1, 1'b0, 3'd0, 1'b1);
        txn(1'b0, 1'b1, 3'd4, 1'b1);

        // Fill all eight slots, then one entry too many.
        #2 do_reset();
        pattern = 3'b101;
        for (int i = 0; i < 9; i++) txn(1'b1, 1'b0, 3'd0, 1'b1);

        // Simultaneous requests twice: entry, exit, entry, exit.
        #2 do_reset();
        for (int i = 0; i < 2; i++) txn(1'b1, 1'b1, 3'd0 ^ pattern, 1'b1);

        // Duration across the time-counter wrap.
        #2 do_reset();
        wait_serve_at(250);
        txn(1'b1, 1'b0, 3'd0, 1'b1);
        wait_serve_at(4);
        txn(1'b0, 1'b1, 3'd0 ^ pattern, 1'b1);

        // Reset during the gate phase, then a normal request.
        txn(1'b1, 1'b0, 3'd0, 1'b0);
        #2 do_reset();
        txn(1'b1, 1'b0, 3'd0, 1'b1);

        // Reset while a request is being served: it must vanish without an ack.
        entry_req = 1'b1;
        @(negedge clk);
        #2 do_reset();
        txn(1'b1, 1'b0, 3'd0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) pattern = 3'($urandom_range(0, 7));
            if (r < 50)      txn(1'b1, 1'b0, pick_token(), 1'b1);
            else if (r < 85) txn(1'b0, 1'b1, pick_token(), 1'b1);
            else             txn(1'b1, 1'b1, pick_token(), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
